// File: rtl/pilha_pkg.sv
// Shared types and constants for the data-stack (Pilha) read side.
// Used by the operand-fetch sequencer and its ULA handoff interface.
package pilha_pkg;

  localparam int DATA_W    = 16;
  localparam int PILHA_LAT = 1;

  typedef enum logic [2:0] {
    OCIOSO,
    POP1,
    CAP1,
    POP2,
    CAP2,
    ENTREGA,
    ERRO
  } busca_estado_t;

endpackage

// File: rtl/busca_operandos_if.sv
// Operand handoff to the ULA: op_a/op_b qualified by op_valid,
// accepted with ula_ready.
interface busca_operandos_if
  import pilha_pkg::*;
#(
  parameter int W = DATA_W
) ();

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_valid;
  logic         ula_ready;

  modport master (
    output op_a,
    output op_b,
    output op_valid,
    input  ula_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_valid,
    output ula_ready
  );

endinterface

// File: rtl/busca_operandos.sv
// Operand-fetch sequencer: pops one or two words from the stack
// and hands them to the ULA, flagging underflow instead of popping.
module busca_operandos
  import pilha_pkg::*;
#(
  parameter int DATA_W = pilha_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uc_req,
  input  logic              uc_dois_op,
  output logic              busy,
  output logic              pilha_pop,
  input  logic [DATA_W-1:0] pilha_dout,
  input  logic              pilha_vazia,
  output logic              erro,
  input  logic              limpa_erro,
  busca_operandos_if.master ula
);

  // The CAPx states sample pilha_dout exactly one cycle after POPx.
  if (PILHA_LAT != 1) begin : g_lat_chk
    $error("busca_operandos requires PILHA_LAT == 1");
  end

  busca_estado_t     state_q;
  logic              dois_q;
  logic              erro_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OCIOSO;
      dois_q  <= 1'b0;
      erro_q  <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      unique case (state_q)
        OCIOSO: begin
          if (uc_req) begin
            dois_q <= uc_dois_op;
            if (pilha_vazia) begin
              state_q <= ERRO;
              erro_q  <= 1'b1;
            end else begin
              state_q <= POP1;
            end
          end
        end
        POP1: state_q <= CAP1;
        CAP1: begin
          op_b_q <= pilha_dout;
          if (dois_q) begin
            if (pilha_vazia) begin
              state_q <= ERRO;
              erro_q  <= 1'b1;
            end else begin
              state_q <= POP2;
            end
          end else begin
            op_a_q  <= '0;
            state_q <= ENTREGA;
          end
        end
        POP2: state_q <= CAP2;
        CAP2: begin
          op_a_q  <= pilha_dout;
          state_q <= ENTREGA;
        end
        ENTREGA: begin
          if (ula.ula_ready) state_q <= OCIOSO;
        end
        ERRO: begin
          if (limpa_erro) begin
            erro_q  <= 1'b0;
            state_q <= OCIOSO;
          end
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign busy         = (state_q != OCIOSO);
  assign pilha_pop    = (state_q == POP1) || (state_q == POP2);
  assign erro         = erro_q;
  assign ula.op_valid = (state_q == ENTREGA);
  assign ula.op_a     = op_a_q;
  assign ula.op_b     = op_b_q;

endmodule

// File: tb/tb_busca_operandos.sv
// Bench for busca_operandos: stack model, scoreboard on the ULA
// handoff, and directed cycle checks of pops, errors and reset.
module tb_busca_operandos;
  import pilha_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uc_req = 1'b0;
  logic        uc_dois_op = 1'b0;
  logic        limpa_erro = 1'b0;
  logic        busy;
  logic        pilha_pop;
  logic        pilha_vazia;
  logic        erro;
  logic [15:0] pilha_dout;

  busca_operandos_if bif ();

  busca_operandos #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .uc_req     (uc_req),
    .uc_dois_op (uc_dois_op),
    .busy       (busy),
    .pilha_pop  (pilha_pop),
    .pilha_dout (pilha_dout),
    .pilha_vazia(pilha_vazia),
    .erro       (erro),
    .limpa_erro (limpa_erro),
    .ula        (bif)
  );

  always #5 clk = ~clk;

  // Stack model: 1-cycle read latency, empty flag from the pointer.
  logic [15:0] stk  [4];
  logic [15:0] ld_v [4];
  int          sp;
  int          npop;
  int          ld_n;
  logic        ld = 1'b0;

  always @(posedge clk) begin
    if (ld) begin
      sp   <= ld_n;
      npop <= 0;
      for (int i = 0; i < 4; i++) stk[i] <= ld_v[i];
    end else if (pilha_pop) begin
      npop <= npop + 1;
      if (sp > 0) begin
        pilha_dout <= stk[sp-1];
        sp         <= sp - 1;
      end
    end
  end

  assign pilha_vazia = (sp == 0);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && bif.op_valid) begin
      if (q.size() == 0) begin
        check("op_valid_inesperado", {31'd0, bif.op_valid}, 32'd0);
      end else begin
        check("sb_op_a", {16'd0, bif.op_a}, {16'd0, q[0].a});
        check("sb_op_b", {16'd0, bif.op_b}, {16'd0, q[0].b});
        if (bif.ula_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [15:0] a,
                      input logic [15:0] b);
    ld_v[0] = a;
    ld_v[1] = b;
    ld_v[2] = '0;
    ld_v[3] = '0;
    ld_n    = n;
    ld      = 1'b1;
    tick();
    ld      = 1'b0;
  endtask

  task automatic req(input logic dois);
    uc_req     = 1'b1;
    uc_dois_op = dois;
    tick();
    uc_req     = 1'b0;
  endtask

  initial begin
    bif.ula_ready = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pop", {31'd0, pilha_pop}, 0);
    check("rst_valid", {31'd0, bif.op_valid}, 0);
    check("rst_erro", {31'd0, erro}, 0);
    check("rst_op_a", {16'd0, bif.op_a}, 0);
    check("rst_op_b", {16'd0, bif.op_b}, 0);
    tick();
    rst = 1'b1;

    // Two operands, stack [3,2]
    load(2, 16'd3, 16'd2);
    bif.ula_ready = 1'b1;
    q.push_back('{a: 16'd3, b: 16'd2});
    req(1'b1);
    check("t1_busy_e0", {31'd0, busy}, 1);
    check("t1_pop_e0", {31'd0, pilha_pop}, 1);
    tick();
    check("t1_pop_e1", {31'd0, pilha_pop}, 0);
    tick();
    check("t1_pop_e2", {31'd0, pilha_pop}, 1);
    tick();
    check("t1_pop_e3", {31'd0, pilha_pop}, 0);
    check("t1_valid_e3", {31'd0, bif.op_valid}, 0);
    tick();
    check("t1_valid_e4", {31'd0, bif.op_valid}, 1);
    tick();
    check("t1_busy_e5", {31'd0, busy}, 0);
    check("t1_vazia", {31'd0, pilha_vazia}, 1);
    check("t1_npop", npop, 2);

    // One operand, stack [7]
    load(1, 16'd7, 16'd0);
    q.push_back('{a: 16'd0, b: 16'd7});
    req(1'b0);
    check("t2_pop_e0", {31'd0, pilha_pop}, 1);
    tick();
    check("t2_valid_e1", {31'd0, bif.op_valid}, 0);
    tick();
    check("t2_valid_e2", {31'd0, bif.op_valid}, 1);
    check("t2_op_a", {16'd0, bif.op_a}, 0);
    check("t2_op_b", {16'd0, bif.op_b}, 7);
    tick();
    check("t2_busy_e3", {31'd0, busy}, 0);
    check("t2_npop", npop, 1);

    // Backpressure with an ignored request
    load(2, 16'd9, 16'd4);
    bif.ula_ready = 1'b0;
    q.push_back('{a: 16'd9, b: 16'd4});
    req(1'b1);
    repeat (4) tick();
    check("t3_valid_e4", {31'd0, bif.op_valid}, 1);
    for (int i = 0; i < 3; i++) begin
      uc_req = (i == 0);
      tick();
      uc_req = 1'b0;
      check("t3_valid_hold", {31'd0, bif.op_valid}, 1);
      check("t3_pop_hold", {31'd0, pilha_pop}, 0);
    end
    bif.ula_ready = 1'b1;
    tick();
    check("t3_busy_handoff", {31'd0, busy}, 0);
    tick();
    check("t3_busy_after", {31'd0, busy}, 0);
    check("t3_npop", npop, 2);

    // Underflow on the second pop, stack [5]
    load(1, 16'd5, 16'd0);
    req(1'b1);
    repeat (2) tick();
    check("t4a_erro", {31'd0, erro}, 1);
    check("t4a_busy", {31'd0, busy}, 1);
    repeat (3) tick();
    check("t4a_erro_sticky", {31'd0, erro}, 1);
    check("t4a_npop", npop, 1);
    limpa_erro = 1'b1;
    tick();
    limpa_erro = 1'b0;
    check("t4a_erro_clr", {31'd0, erro}, 0);
    check("t4a_busy_clr", {31'd0, busy}, 0);

    // Underflow on an empty stack
    load(0, 16'd0, 16'd0);
    req(1'b0);
    check("t4b_erro_e0", {31'd0, erro}, 1);
    check("t4b_pop_e0", {31'd0, pilha_pop}, 0);
    repeat (2) tick();
    check("t4b_npop", npop, 0);
    check("t4b_erro_sticky", {31'd0, erro}, 1);
    limpa_erro = 1'b1;
    tick();
    limpa_erro = 1'b0;
    check("t4b_erro_clr", {31'd0, erro}, 0);
    check("t4b_busy_clr", {31'd0, busy}, 0);

    // Asynchronous reset during CAP1
    load(2, 16'd1, 16'd2);
    req(1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_pop", {31'd0, pilha_pop}, 0);
    check("t5_valid", {31'd0, bif.op_valid}, 0);
    check("t5_erro", {31'd0, erro}, 0);
    check("t5_op_a", {16'd0, bif.op_a}, 0);
    check("t5_op_b", {16'd0, bif.op_b}, 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    check("t5_npop", npop, 1);

    load(2, 16'd6, 16'd8);
    q.push_back('{a: 16'd6, b: 16'd8});
    req(1'b1);
    for (int i = 0; i < 20 && busy; i++) tick();
    check("t5_fim_busy", {31'd0, busy}, 0);
    check("t5_npop2", npop, 2);
    check("sb_vazio", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
